manchester_decoder: RTL and testbench

//  Receive-side counterpart of the Manchester TX stage. Oversamples the raw RF line, acquires bit

---
 rtl/manchester_decoder_pkg.sv | 28 ++
 rtl/rf_sync_edge.sv | 31 +++
 rtl/manchester_decoder.sv | 138 +++++++++++++
 tb/tb_manchester_decoder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/manchester_decoder_pkg.sv
// Shared definitions for the Manchester receive path: FSM state encodings, idle line level and
// the edge-timing window classifier.
package manchester_decoder_pkg;

  typedef enum logic [1:0] {
    StHunt   = 2'd0,
    StSync   = 2'd1,
    StLocked = 2'd2
  } dec_state_e;

  localparam logic LineIdle = 1'b0;

  typedef enum logic [1:0] {
    WinGlitch,
    WinBoundary,
    WinMid,
    WinTimeout
  } edge_win_e;

  // cnt counts cycles since the last accepted mid-bit edge; q is a quarter bit period.
  function automatic edge_win_e classify_edge(int unsigned cnt, int unsigned q);
    if (cnt >= 5 * q + 1) return WinTimeout;
    if (cnt >= 3 * q) return WinMid;
    if (cnt >= q) return WinBoundary;
    return WinGlitch;
  endfunction

endpackage

// File: rtl/rf_sync_edge.sv
// Two-flop synchronizer for an asynchronous line followed by a registered-history edge detector.
module rf_sync_edge #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic s1_q, s2_q, s2_d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= ResetVal;
      s2_q   <= ResetVal;
      s2_d_q <= ResetVal;
    end else begin
      s1_q   <= d;
      s2_q   <= s1_q;
      s2_d_q <= s2_q;
    end
  end

  assign q    = s2_q;
  assign rise = s2_q & ~s2_d_q;
  assign fall = ~s2_q & s2_d_q;

endmodule

// File: rtl/manchester_decoder.sv
// Manchester line decoder: locks onto an alternating preamble, then recovers NRZ bits from
// mid-bit transitions (falling = 1, rising = 0) with a one-cycle valid strobe.
module manchester_decoder
  import manchester_decoder_pkg::*;
#(
  parameter int unsigned OVERSAMPLE     = 16,
  parameter int unsigned PREAMBLE_EDGES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  input  logic enable,
  output logic dout,
  output logic dout_valid,
  output logic locked,
  output logic err
);

  localparam int unsigned Q      = OVERSAMPLE / 4;
  localparam int unsigned CNT_W  = $clog2(5 * Q + 2);
  localparam int unsigned PCNT_W = $clog2(PREAMBLE_EDGES + 1);
  localparam logic [CNT_W-1:0]  CntMax  = CNT_W'(5 * Q + 1);
  localparam logic [PCNT_W-1:0] PcntTop = PCNT_W'(PREAMBLE_EDGES - 1);

  logic line_q, rise, fall, edge_any;
  edge_win_e win;

  dec_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic              bflag_q, bflag_d;
  logic              dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  rf_sync_edge #(
    .ResetVal(LineIdle)
  ) u_sync_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (din),
    .q    (line_q),
    .rise (rise),
    .fall (fall)
  );

  assign edge_any = rise | fall;
  assign win      = classify_edge(32'(cnt_q), Q);

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    pcnt_d  = pcnt_q;
    bflag_d = bflag_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    if (!enable) begin
      state_d = StHunt;
      cnt_d   = '0;
      pcnt_d  = '0;
      bflag_d = 1'b0;
    end else begin
      unique case (state_q)
        StHunt: begin
          // Saturated cnt is irrelevant here: any edge becomes the first timing reference.
          if (edge_any) begin
            state_d = StSync;
            cnt_d   = '0;
            pcnt_d  = '0;
          end
        end
        StSync: begin
          if (win == WinTimeout) begin
            state_d = StHunt;
          end else if (edge_any) begin
            cnt_d = '0;
            if (win == WinMid) begin
              pcnt_d = pcnt_q + 1'b1;
              if (pcnt_q == PcntTop) begin
                state_d = StLocked;
                bflag_d = 1'b0;
              end
            end else begin
              pcnt_d = '0;
            end
          end
        end
        StLocked: begin
          if (win == WinTimeout) begin
            err_d   = 1'b1;
            state_d = StHunt;
          end else if (edge_any) begin
            if (win == WinMid) begin
              dout_d  = ~line_q;
              valid_d = 1'b1;
              cnt_d   = '0;
              bflag_d = 1'b0;
            end else if (win == WinBoundary && !bflag_q) begin
              bflag_d = 1'b1;
            end else begin
              err_d   = 1'b1;
              state_d = StHunt;
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StHunt;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      bflag_q <= 1'b0;
      dout_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      bflag_q <= bflag_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign err        = err_q;
  assign locked     = (state_q == StLocked);

endmodule

// File: tb/tb_manchester_decoder.sv
// Bench for manchester_decoder: table-driven scenarios, random jittered streams against an
// edge-timestamp reference model, and hand-written reset/enable interruptions.
`timescale 1ns/1ps
module tb_manchester_decoder;

  localparam int Q        = 4;
  localparam int Half     = 8;
  localparam int PreEdges = 8;
  localparam int MHunt    = 0;
  localparam int MSync    = 1;
  localparam int MLocked  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din = 1'b0;
  logic enable = 1'b1;
  logic dout, dout_valid, locked, err;

  manchester_decoder #(
    .OVERSAMPLE    (16),
    .PREAMBLE_EDGES(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .enable    (enable),
    .dout      (dout),
    .dout_valid(dout_valid),
    .locked    (locked),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          pre_bits;
    logic [7:0]  data;
    int          kind;       // 0 clean, 1 early/late mid edges, 2 hold, 3 glitch+relock, 4 stretch
    int          exp_valid;
    logic [15:0] exp_bits;
    int          exp_err;
    bit          exp_lock;
  } vec_t;

  vec_t vecs[8];

  int checks = 0;
  int failures = 0;
  int nvalid, nerr;
  logic [15:0] bits;
  bit ever_locked;

  bit stim[$];
  bit m_valid[], m_err[], m_lock[], m_bitv[], m_dout[];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic add_level(input bit v, input int n);
    for (int k = 0; k < n; k++) stim.push_back(v);
  endtask

  task automatic add_bit(input bit b, input int h1, input int h2);
    add_level(b, h1);
    add_level(!b, h2);
  endtask

  task automatic add_preamble(input int nbits, input int stretch_idx);
    for (int k = 0; k < nbits; k++) add_bit((k % 2) == 0, Half, (k == stretch_idx) ? 14 : Half);
  endtask

  task automatic add_byte(input logic [7:0] v);
    for (int k = 7; k >= 0; k--) add_bit(v[k], Half, Half);
  endtask

  // Reference model over edge timestamps. An edge of din sampled at posedge n is seen by the
  // decoder in interval n+1; its response appears one interval later.
  task automatic build_model();
    int len, mode, r, p, i, e, c, deadline, lock_start;
    int edges[$];
    bit bf, cur;
    len = stim.size();
    m_valid = new[len];
    m_err   = new[len];
    m_lock  = new[len];
    m_bitv  = new[len];
    m_dout  = new[len];
    for (int n = 0; n < len - 1; n++)
      if (stim[n] != ((n == 0) ? 1'b0 : stim[n-1])) edges.push_back(n + 1);
    mode = MHunt; r = 0; p = 0; i = 0; bf = 1'b0; lock_start = 0;
    while (!(mode == MHunt && i >= edges.size())) begin
      if (mode == MHunt) begin
        r = edges[i]; i++; mode = MSync; p = 0;
      end else begin
        deadline = r + 5 * Q + 2;
        if (i < edges.size() && edges[i] < deadline) begin
          e = edges[i]; i++; c = e - r - 1;
          if (mode == MSync) begin
            r = e;
            if (c >= 3 * Q) begin
              p++;
              if (p == PreEdges) begin mode = MLocked; lock_start = e + 1; bf = 1'b0; end
            end else p = 0;
          end else if (c >= 3 * Q) begin
            if (e + 1 < len) begin m_valid[e+1] = 1'b1; m_bitv[e+1] = (stim[e-1] == 1'b0); end
            r = e; bf = 1'b0;
          end else if (c >= Q && !bf) begin
            bf = 1'b1;
          end else begin
            if (e + 1 < len) m_err[e+1] = 1'b1;
            for (int t = lock_start; t < e + 1 && t < len; t++) m_lock[t] = 1'b1;
            mode = MHunt;
          end
        end else begin
          if (mode == MLocked) begin
            if (deadline + 1 < len) m_err[deadline+1] = 1'b1;
            for (int t = lock_start; t < deadline + 1 && t < len; t++) m_lock[t] = 1'b1;
          end
          mode = MHunt;
          while (i < edges.size() && edges[i] <= deadline) i++;
        end
      end
    end
    cur = 1'b0;
    for (int t = 0; t < len; t++) begin
      if (m_valid[t]) cur = m_bitv[t];
      m_dout[t] = cur;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b1; din = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic tally();
    if (dout_valid) begin nvalid++; bits = {bits[14:0], dout}; end
    if (err) nerr++;
    if (locked) ever_locked = 1'b1;
  endtask

  task automatic run_checked();
    build_model();
    do_reset();
    nvalid = 0; nerr = 0; bits = '0; ever_locked = 1'b0;
    for (int n = 0; n < stim.size(); n++) begin
      din = stim[n];
      @(posedge clk);
      @(negedge clk);
      check($sformatf("cycle_%0d lock/valid/dout/err", n), {locked, dout_valid, dout, err},
            {m_lock[n], m_valid[n], m_dout[n], m_err[n]});
      tally();
    end
  endtask

  task automatic gen_scenario(input vec_t tv);
    stim.delete();
    add_level(1'b0, 10);
    add_preamble(tv.pre_bits, (tv.kind == 4) ? 4 : -1);
    if (tv.kind != 4) begin
      for (int k = 7; k >= 0; k--) begin
        if (tv.kind == 2 && k == 3) break;
        if (tv.kind == 3 && k == 5) begin
          // Bit '1' with a 2-sample high glitch seen at cnt=2 after its mid edge.
          add_level(1'b1, 8); add_level(1'b0, 3); add_level(1'b1, 2); add_level(1'b0, 3);
        end else begin
          add_bit(tv.data[k], (tv.kind == 1 && k == 3) ? 13 : Half,
                  (tv.kind == 1 && k == 5) ? 5 : Half);
        end
      end
    end
    if (tv.kind == 2) add_level(stim[$], 40);
    if (tv.kind == 3) begin
      add_level(1'b0, 40);
      add_preamble(9, -1);
      add_byte(8'h3C);
    end
    add_level(1'b0, 40);
  endtask

  function automatic int jitter();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return $urandom_range(1, 3);
    if (r == 1) return $urandom_range(12, 16);
    return $urandom_range(7, 9);
  endfunction

  task automatic gen_random();
    int nb;
    stim.delete();
    add_level(1'b0, $urandom_range(5, 30));
    for (int s = 0; s < 2; s++) begin
      nb = $urandom_range(8, 12);
      for (int k = 0; k < nb; k++) add_bit((k % 2) == 0, $urandom_range(7, 9), $urandom_range(7, 9));
      nb = $urandom_range(4, 16);
      for (int k = 0; k < nb; k++) add_bit(1'($urandom_range(0, 1)), jitter(), jitter());
      add_level(1'b0, $urandom_range(25, 40));
    end
  endtask

  task automatic run_interrupt(input bit use_reset);
    string tag;
    tag = use_reset ? "rst" : "en";
    stim.delete();
    add_level(1'b0, 10); add_preamble(9, -1); add_byte(8'hA5); add_level(1'b0, 40);
    add_preamble(9, -1); add_byte(8'h3C); add_level(1'b0, 40);
    do_reset();
    nvalid = 0; nerr = 0; bits = '0;
    for (int n = 0; n < stim.size(); n++) begin
      din = stim[n];
      if (n == 224) begin
        check({tag, "_pre_valid"}, nvalid, 4);
        check({tag, "_pre_bits"}, bits, 16'h000A);
        check({tag, "_pre_locked"}, locked, 1);
        nvalid = 0; nerr = 0; bits = '0;
        if (!use_reset) enable = 1'b0;
      end
      if (n == 260) begin
        check({tag, "_window_quiet"}, nvalid + nerr, 0);
        if (use_reset) rst_n = 1'b1; else enable = 1'b1;
      end
      @(posedge clk);
      if (n == 224 && use_reset) begin
        #2 rst_n = 1'b0;
        #1 check("rst_async_outputs", {locked, dout_valid, dout, err}, 4'b0000);
      end
      @(negedge clk);
      if (n == 224 && !use_reset) check("en_off_outputs", {locked, dout_valid, dout, err}, 4'b0000);
      tally();
    end
    check({tag, "_relock_valid"}, nvalid, 8);
    check({tag, "_relock_bits"}, bits, 16'h003C);
    check({tag, "_relock_err"}, nerr, 1);
  endtask

  initial begin
    vecs[0] = '{9, 8'hA5, 0, 8, 16'h00A5, 1, 1'b1};
    vecs[1] = '{9, 8'hA5, 1, 8, 16'h00A5, 1, 1'b1};
    vecs[2] = '{9, 8'hA5, 2, 4, 16'h000A, 1, 1'b1};
    vecs[3] = '{9, 8'hA5, 3, 11, 16'h053C, 2, 1'b1};
    vecs[4] = '{9, 8'hA5, 4, 0, 16'h0000, 0, 1'b0};
    vecs[5] = '{9, 8'h00, 0, 8, 16'h0000, 1, 1'b1};
    vecs[6] = '{9, 8'hFF, 0, 8, 16'h00FF, 1, 1'b1};
    // With exactly 8 preamble bits the first one is consumed as timing reference, so lock
    // lands on the first payload bit and only the remaining 7 are delivered.
    vecs[7] = '{8, 8'hA5, 0, 7, 16'h0025, 1, 1'b1};

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {locked, dout_valid, dout, err}, 4'b0000);

    for (int v = 0; v < 8; v++) begin
      gen_scenario(vecs[v]);
      run_checked();
      check($sformatf("vec%0d_valid_count", v), nvalid, vecs[v].exp_valid);
      check($sformatf("vec%0d_bits", v), bits, vecs[v].exp_bits);
      check($sformatf("vec%0d_err_count", v), nerr, vecs[v].exp_err);
      check($sformatf("vec%0d_ever_locked", v), ever_locked, vecs[v].exp_lock);
    end

    for (int s = 0; s < 6; s++) begin
      gen_random();
      run_checked();
    end

    run_interrupt(1'b1);
    run_interrupt(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
